scie_fir_sequencer: RTL and testbench

Sequencer that drives the pipelined SCIE complex-FIR datapath (`SCIEPipelined`) from two valid/ready host streams: one for coefficient writes and one for samples. For each coefficient write it issues one load instruction. For each sample it issues the push / gap / read instruction sequence, captures the filtered complex result, and returns it on an output stream through a 2-entry buffer. It sits between the host/accelerator shell and the datapath and is the only agent allowed to drive the datapath's `io_valid`/`io_insn`.

---
 rtl/scie_fir_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_scie_fir_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scie_fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module : scie_fir_sequencer
// Drives load/push/gap/read instructions into the SCIE pipelined complex FIR
// and returns each captured result through a 2-entry output FIFO.
// Option : define SCIE_SEQ_PERF_EN for the perf_samples/perf_busy counters.
// Rev    : 1.0  initial release
// ============================================================================
module scie_fir_sequencer #(
  parameter int NTAPS = 5,
  parameter int DW    = 64,
  parameter int IW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [IW-1:0]    i_cfg_idx,
  input  logic [DW-1:0]    i_cfg_real,
  input  logic [DW-1:0]    i_cfg_imag,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [DW-1:0]    i_in_real,
  input  logic [DW-1:0]    i_in_imag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [DW-1:0]    o_out_real,
  output logic [DW-1:0]    o_out_imag,
  output logic             o_io_valid,
  output logic [31:0]      o_io_insn,
  output logic [DW-1:0]    o_io_rs1_real,
  output logic [DW-1:0]    o_io_rs1_imag,
  output logic [31:0]      o_io_rs2,
  input  logic [DW-1:0]    i_io_rd_real,
  input  logic [DW-1:0]    i_io_rd_imag,
  output logic [NTAPS-1:0] o_coef_loaded,
`ifdef SCIE_SEQ_PERF_EN
  output logic [31:0]      o_perf_samples,
  output logic [31:0]      o_perf_busy,
`endif
  output logic             o_busy
);

  localparam logic [31:0]      c_insn_load = 32'd11;
  localparam logic [31:0]      c_insn_push = 32'd43;
  localparam logic [31:0]      c_insn_read = 32'd91;
  localparam logic [IW:0]      c_ntaps     = NTAPS[IW:0];
  localparam logic [NTAPS-1:0] c_tap0      = {{(NTAPS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PUSH = 3'd2,
    S_GAP  = 3'd3,
    S_READ = 3'd4,
    S_WAIT = 3'd5
  } state_t;

  state_t r_state, w_next;

  logic             w_cfg_hs, w_in_hs, w_idx_ok, w_push, w_pop;
  logic             r_io_valid;
  logic [31:0]      r_io_insn, r_io_rs2;
  logic [DW-1:0]    r_io_rs1_real, r_io_rs1_imag;
  logic [NTAPS-1:0] r_coef_loaded;
  logic [DW-1:0]    r_mem_real [2];
  logic [DW-1:0]    r_mem_imag [2];
  logic             r_wptr, r_rptr;
  logic [1:0]       r_count;

  // A sample is refused while two results are buffered so the in-flight one always has a slot.
  assign o_cfg_ready = (r_state == S_IDLE);
  assign o_in_ready  = (r_state == S_IDLE) && !i_cfg_valid && (r_count <= 2'd1);
  assign w_cfg_hs    = i_cfg_valid && o_cfg_ready;
  assign w_in_hs     = i_in_valid && o_in_ready;
  assign w_idx_ok    = ({1'b0, i_cfg_idx} < c_ntaps);
  assign w_push      = (r_state == S_WAIT);
  assign w_pop       = o_out_valid && i_out_ready;
  assign o_busy      = (r_state != S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cfg_hs)     w_next = S_LOAD;
        else if (w_in_hs) w_next = S_PUSH;
      end
      S_LOAD:  w_next = S_IDLE;
      S_PUSH:  w_next = S_GAP;
      S_GAP:   w_next = S_READ;
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Instruction outputs are registered so they are valid for the whole LOAD/PUSH/READ cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_io_valid    <= 1'b0;
      r_io_insn     <= '0;
      r_io_rs1_real <= '0;
      r_io_rs1_imag <= '0;
      r_io_rs2      <= '0;
      r_coef_loaded <= '0;
    end else begin
      r_io_valid <= 1'b0;
      r_io_insn  <= '0;
      if (w_cfg_hs) begin
        if (w_idx_ok) begin
          r_io_valid    <= 1'b1;
          r_io_insn     <= c_insn_load;
          r_io_rs1_real <= i_cfg_real;
          r_io_rs1_imag <= i_cfg_imag;
          r_io_rs2      <= {{(32-IW){1'b0}}, i_cfg_idx};
          r_coef_loaded <= r_coef_loaded | (c_tap0 << i_cfg_idx);
        end
      end else if (w_in_hs) begin
        r_io_valid    <= 1'b1;
        r_io_insn     <= c_insn_push;
        r_io_rs1_real <= i_in_real;
        r_io_rs1_imag <= i_in_imag;
      end else if (r_state == S_GAP) begin
        r_io_valid <= 1'b1;
        r_io_insn  <= c_insn_read;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_real[0] <= '0;
      r_mem_real[1] <= '0;
      r_mem_imag[0] <= '0;
      r_mem_imag[1] <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem_real[r_wptr] <= i_io_rd_real;
        r_mem_imag[r_wptr] <= i_io_rd_imag;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SCIE_SEQ_PERF_EN
  logic [31:0] r_perf_samples, r_perf_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_samples <= '0;
      r_perf_busy    <= '0;
    end else begin
      if (w_push) r_perf_samples <= r_perf_samples + 32'd1;
      if (o_busy) r_perf_busy    <= r_perf_busy + 32'd1;
    end
  end

  assign o_perf_samples = r_perf_samples;
  assign o_perf_busy    = r_perf_busy;
`endif

  assign o_io_valid    = r_io_valid;
  assign o_io_insn     = r_io_insn;
  assign o_io_rs1_real = r_io_rs1_real;
  assign o_io_rs1_imag = r_io_rs1_imag;
  assign o_io_rs2      = r_io_rs2;
  assign o_coef_loaded = r_coef_loaded;
  assign o_out_valid   = (r_count != 2'd0);
  assign o_out_real    = r_mem_real[r_rptr];
  assign o_out_imag    = r_mem_imag[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_scie_fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_scie_fir_sequencer
// Bench for scie_fir_sequencer with a behavioural FIR datapath and scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_scie_fir_sequencer;
  localparam int NTAPS = 5;
  localparam int DW    = 64;
  localparam int IW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_valid = 1'b0, cfg_ready;
  logic [IW-1:0]    cfg_idx = '0;
  logic [DW-1:0]    cfg_real = '0, cfg_imag = '0;
  logic             in_valid = 1'b0, in_ready;
  logic [DW-1:0]    in_real = '0, in_imag = '0;
  logic             out_valid, out_ready = 1'b1;
  logic [DW-1:0]    out_real, out_imag;
  logic             io_valid;
  logic [31:0]      io_insn, io_rs2;
  logic [DW-1:0]    io_rs1_real, io_rs1_imag;
  logic [DW-1:0]    io_rd_real, io_rd_imag;
  logic [NTAPS-1:0] coef_loaded;
  logic             busy;
`ifdef SCIE_SEQ_PERF_EN
  logic [31:0]      perf_samples, perf_busy;
`endif

  scie_fir_sequencer #(.NTAPS(NTAPS), .DW(DW), .IW(IW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_idx(cfg_idx),
    .i_cfg_real(cfg_real), .i_cfg_imag(cfg_imag),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_real(in_real), .i_in_imag(in_imag),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_real(out_real), .o_out_imag(out_imag),
    .o_io_valid(io_valid), .o_io_insn(io_insn),
    .o_io_rs1_real(io_rs1_real), .o_io_rs1_imag(io_rs1_imag), .o_io_rs2(io_rs2),
    .i_io_rd_real(io_rd_real), .i_io_rd_imag(io_rd_imag),
    .o_coef_loaded(coef_loaded),
`ifdef SCIE_SEQ_PERF_EN
    .o_perf_samples(perf_samples), .o_perf_busy(perf_busy),
`endif
    .o_busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit rand_or = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural datapath: taps and a shift-register history; result = sum(c*x) >>> 8.
  // Outside the cycle after a read the result bus carries junk.
  longint dp_tr[NTAPS], dp_ti[NTAPS], dp_hr[NTAPS], dp_hi[NTAPS];
  initial for (int k = 0; k < NTAPS; k++) begin dp_tr[k] = 0; dp_ti[k] = 0; end

  function automatic longint dp_sum(input bit im);
    longint acc = 0;
    for (int k = 0; k < NTAPS; k++)
      acc += im ? (dp_tr[k] * dp_hi[k] + dp_ti[k] * dp_hr[k])
                : (dp_tr[k] * dp_hr[k] - dp_ti[k] * dp_hi[k]);
    return acc >>> 8;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin dp_hr[k] <= 0; dp_hi[k] <= 0; end
      io_rd_real <= '0;
      io_rd_imag <= '0;
    end else begin
      io_rd_real <= {$urandom, $urandom};
      io_rd_imag <= {$urandom, $urandom};
      if (io_valid && io_insn == 32'd11 && io_rs2 < 32'd5) begin
        dp_tr[io_rs2[2:0]] <= io_rs1_real;
        dp_ti[io_rs2[2:0]] <= io_rs1_imag;
      end
      if (io_valid && io_insn == 32'd43) begin
        dp_hr[0] <= io_rs1_real;
        dp_hi[0] <= io_rs1_imag;
        for (int k = 1; k < NTAPS; k++) begin dp_hr[k] <= dp_hr[k-1]; dp_hi[k] <= dp_hi[k-1]; end
      end
      if (io_valid && io_insn == 32'd91) begin
        io_rd_real <= dp_sum(1'b0);
        io_rd_imag <= dp_sum(1'b1);
      end
    end
  end

  // Scoreboard: host-side view of the taps and the most recent accepted samples.
  longint sb_cr[NTAPS], sb_ci[NTAPS];
  longint sb_xr[$], sb_xi[$];
  longint exp_r[$], exp_i[$], got_r[$], got_i[$];
  initial for (int k = 0; k < NTAPS; k++) begin sb_cr[k] = 0; sb_ci[k] = 0; end

  function automatic void sb_accept(input longint xr, input longint xi);
    longint yr = 0, yi = 0;
    sb_xr.push_front(xr);
    sb_xi.push_front(xi);
    if (sb_xr.size() > NTAPS) begin void'(sb_xr.pop_back()); void'(sb_xi.pop_back()); end
    foreach (sb_xr[k]) begin
      yr += sb_cr[k] * sb_xr[k] - sb_ci[k] * sb_xi[k];
      yi += sb_cr[k] * sb_xi[k] + sb_ci[k] * sb_xr[k];
    end
    exp_r.push_back(yr >>> 8);
    exp_i.push_back(yi >>> 8);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_valid && cfg_ready && cfg_idx < 3'd5) begin
        sb_cr[cfg_idx] = longint'($signed(cfg_real));
        sb_ci[cfg_idx] = longint'($signed(cfg_imag));
      end
      if (in_valid && in_ready) sb_accept(longint'($signed(in_real)), longint'($signed(in_imag)));
      if (out_valid && out_ready) begin
        got_r.push_back(longint'($signed(out_real)));
        got_i.push_back(longint'($signed(out_imag)));
      end
    end
  end

  task automatic cmp_outputs();
    while (got_r.size() > 0 && exp_r.size() > 0) begin
      chk("sb_out_real", got_r.pop_front(), exp_r.pop_front());
      chk("sb_out_imag", got_i.pop_front(), exp_i.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_cfg(input logic [IW-1:0] idx, input longint re, input longint im);
    bit got = 1'b0;
    cfg_valid = 1'b1; cfg_idx = idx; cfg_real = re; cfg_imag = im;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      got = cfg_ready;
      tick();
      if (got) break;
    end
    cfg_valid = 1'b0;
    if (!got) chk("cfg_accept_timeout", 0, 1);
  endtask

  task automatic do_sample(input longint re, input longint im);
    bit got = 1'b0;
    in_valid = 1'b1; in_real = re; in_imag = im;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      got = in_ready;
      tick();
      if (got) break;
    end
    in_valid = 1'b0;
    if (!got) chk("in_accept_timeout", 0, 1);
  endtask

  // Called right after the accept edge: walks PUSH, GAP, READ, WAIT and the first output cycle.
  task automatic chk_sample_seq(input longint re, input longint im, input longint er, input longint ei);
    @(negedge clk);
    chk("push_valid", io_valid, 1); chk("push_insn", io_insn, 43);
    chk("push_rs1_real", io_rs1_real, re); chk("push_rs1_imag", io_rs1_imag, im);
    chk("push_out_valid", out_valid, 0);
    tick(); @(negedge clk);
    chk("gap_valid", io_valid, 0); chk("gap_insn", io_insn, 0);
    tick(); @(negedge clk);
    chk("read_valid", io_valid, 1); chk("read_insn", io_insn, 91);
    tick(); @(negedge clk);
    chk("wait_valid", io_valid, 0); chk("wait_out_valid", out_valid, 0);
    tick(); @(negedge clk);
    chk("lat_out_valid", out_valid, 1); chk("lat_busy", busy, 0);
    chk("res_real", out_real, er); chk("res_imag", out_imag, ei);
    tick();
  endtask

  typedef struct {
    bit            is_cfg;
    logic [IW-1:0] idx;
    longint        re, im, er, ei;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    vt[0] = '{1'b1, 3'd0,   9007,   -728,       0,       0};
    vt[1] = '{1'b1, 3'd1, -10319,   1238,       0,       0};
    vt[2] = '{1'b1, 3'd2,  -7128,  12307,       0,       0};
    vt[3] = '{1'b1, 3'd3,    290,  -6319,       0,       0};
    vt[4] = '{1'b1, 3'd4,  -5975,  12258,       0,       0};
    vt[5] = '{1'b0, 3'd0,   9431,  -4819,  318112, -196370};
    vt[6] = '{1'b0, 3'd0,   2883,   5233, -240531,  415772};

    // Reset values
    #12;
    chk("rst_io_valid", io_valid, 0); chk("rst_io_insn", io_insn, 0);
    chk("rst_rs1", io_rs1_real, 0); chk("rst_rs2", io_rs2, 0);
    chk("rst_out_valid", out_valid, 0); chk("rst_out_real", out_real, 0);
    chk("rst_coef_loaded", coef_loaded, 0); chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1); chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // Directed taps and first two samples
    for (int v = 0; v < 7; v++) begin
      if (vt[v].is_cfg) begin
        do_cfg(vt[v].idx, vt[v].re, vt[v].im);
        @(negedge clk);
        chk("load_valid", io_valid, 1); chk("load_insn", io_insn, 11);
        chk("load_rs2", io_rs2, vt[v].idx); chk("load_rs1_real", io_rs1_real, vt[v].re);
        chk("load_rs1_imag", io_rs1_imag, vt[v].im); chk("load_busy", busy, 1);
        tick();
      end else begin
        do_sample(vt[v].re, vt[v].im);
        chk_sample_seq(vt[v].re, vt[v].im, vt[v].er, vt[v].ei);
      end
    end
    @(negedge clk);
    chk("coef_loaded_all", coef_loaded, 5'b11111);
    tick(); cmp_outputs();

    // Out-of-range index: accepted, nothing issued
    do_cfg(3'd6, 77, 77);
    @(negedge clk);
    chk("bad_idx_valid", io_valid, 0); chk("bad_idx_coef", coef_loaded, 5'b11111);
    chk("bad_idx_busy", busy, 1);
    tick();

    // Simultaneous cfg and sample: cfg wins, sample accepted two cycles later
    cfg_valid = 1'b1; cfg_idx = 3'd2; cfg_real = 100; cfg_imag = -50;
    in_valid = 1'b1; in_real = 1500; in_imag = -2500;
    @(negedge clk);
    chk("sim_in_ready", in_ready, 0); chk("sim_cfg_ready", cfg_ready, 1);
    tick(); cfg_valid = 1'b0;
    @(negedge clk);
    chk("sim_load_insn", io_insn, 11); chk("sim_load_rs2", io_rs2, 2); chk("sim_in_blocked", in_ready, 0);
    tick();
    @(negedge clk);
    chk("sim_in_ready_later", in_ready, 1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("sim_push_insn", io_insn, 43);
    repeat (6) tick();
    cmp_outputs();

    // Back-pressure: two results held, third sample blocked until drained
    out_ready = 1'b0;
    do_sample(-321, 654);
    do_sample(4000, 12);
    in_valid = 1'b1; in_real = -77; in_imag = -88;
    repeat (10) tick();
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0); chk("bp_out_valid", out_valid, 1);
    chk("bp_busy", busy, 0); chk("bp_nothing_popped", got_r.size(), 0);
    tick();
    out_ready = 1'b1;
    do_sample(-77, -88);
    repeat (8) tick();
    chk("bp_drained_count", got_r.size(), 3);
    cmp_outputs();

    // Reset asserted during GAP
    do_sample(9431, -4819);
    @(negedge clk);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_io_valid", io_valid, 0); chk("mrst_io_insn", io_insn, 0);
    chk("mrst_out_valid", out_valid, 0); chk("mrst_busy", busy, 0);
    chk("mrst_coef_loaded", coef_loaded, 0); chk("mrst_rs1", io_rs1_real, 0);
    cmp_outputs();
    exp_r.delete(); exp_i.delete(); sb_xr.delete(); sb_xi.delete();
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("mrst_no_stale", out_valid, 0);
    tick();
    do_sample(9431, -4819);
    chk_sample_seq(9431, -4819, 318112, -196370);
    tick(); cmp_outputs();

    // Randomized traffic against the scoreboard
    rand_or = 1'b1;
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)
        do_cfg(3'($urandom_range(0, 7)), longint'($urandom_range(0, 40000)) - 20000,
               longint'($urandom_range(0, 40000)) - 20000);
      else if (r < 7)
        do_sample(longint'($urandom_range(0, 40000)) - 20000, longint'($urandom_range(0, 40000)) - 20000);
      else
        tick();
      cmp_outputs();
    end
    rand_or = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    cmp_outputs();
    chk("leftover_got", got_r.size(), 0);
    chk("leftover_exp", exp_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
